// File: rtl/cache_ways.sv
// N-way set-associative tag/data array with registered hit detection, true-LRU ages and line fills.
// Optional feature macro: CACHE_WAYS_UNALIGNED_EN (odd-offset word access).
module cache_ways #(
   parameter int unsigned WAYS       = 2,
   parameter int unsigned SETS       = 8,
   parameter int unsigned LINE_BYTES = 16,
   localparam int unsigned OFF_W     = $clog2(LINE_BYTES),
   localparam int unsigned IDX_W     = $clog2(SETS),
   localparam int unsigned TAG_W     = 16 - IDX_W - OFF_W,
   localparam int unsigned WAY_W     = $clog2(WAYS),
   localparam int unsigned LINE_W    = 8 * LINE_BYTES
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [15:0]       req_addr,
   input  logic              req_write,
   input  logic [15:0]       req_wdata,
   input  logic [1:0]        req_wmask,
   output logic              rsp_valid,
   output logic              rsp_hit,
   output logic [WAY_W-1:0]  rsp_way,
   output logic [15:0]       rsp_rdata,
   output logic              victim_valid,
   output logic              victim_dirty,
   output logic [TAG_W-1:0]  victim_tag,
   output logic [LINE_W-1:0] victim_line,
   input  logic              fill_valid,
   input  logic [15:0]       fill_addr,
   input  logic [LINE_W-1:0] fill_line,
   input  logic              inv_all
);

   logic [WAYS-1:0]       r_valid [SETS];
   logic [WAYS-1:0]       r_dirty [SETS];
   logic [WAYS*WAY_W-1:0] r_age   [SETS];
   logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
   logic [LINE_W-1:0]     r_line  [SETS][WAYS];

   logic [OFF_W-1:0]  w_off_eff;
   logic [31:0]       w_off_i;
   logic [IDX_W-1:0]  w_idx;
   logic [TAG_W-1:0]  w_tag;
   logic [IDX_W-1:0]  w_fidx;
   logic [TAG_W-1:0]  w_ftag;
   logic [WAYS-1:0]   w_hit;
   logic              w_hit_any;
   logic [WAY_W-1:0]  w_hit_way;
   logic [WAY_W-1:0]  w_vict;
   logic [WAY_W-1:0]  w_fvict;
   logic [LINE_W+7:0] w_line_ext;
   logic [15:0]       w_word;
   logic [LINE_W-1:0] w_merged;
   logic              w_accept;

   // Lowest-index invalid way, otherwise the oldest (age WAYS-1).
   function automatic logic [WAY_W-1:0] pick_victim(input logic [WAYS-1:0] valid,
                                                    input logic [WAYS*WAY_W-1:0] ages);
      logic [WAY_W-1:0] pick;
      logic             found;
      pick  = '0;
      found = 1'b0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!valid[w] && !found) begin
            pick  = WAY_W'(w);
            found = 1'b1;
         end
      end
      if (!found) begin
         for (int unsigned w = 0; w < WAYS; w++) begin
            if (ages[w*WAY_W +: WAY_W] == WAY_W'(WAYS-1)) pick = WAY_W'(w);
         end
      end
      return pick;
   endfunction

   function automatic logic [WAYS*WAY_W-1:0] touch(input logic [WAYS*WAY_W-1:0] ages,
                                                  input logic [WAY_W-1:0] way);
      logic [WAYS*WAY_W-1:0] nxt;
      logic [WAY_W-1:0]      a;
      nxt = ages;
      a   = ages[way*WAY_W +: WAY_W];
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (ages[w*WAY_W +: WAY_W] < a) nxt[w*WAY_W +: WAY_W] = ages[w*WAY_W +: WAY_W] + 1'b1;
      end
      nxt[way*WAY_W +: WAY_W] = '0;
      return nxt;
   endfunction

`ifdef CACHE_WAYS_UNALIGNED_EN
   assign w_off_eff = req_addr[OFF_W-1:0];
`else
   assign w_off_eff = {req_addr[OFF_W-1:1], 1'b0};
`endif

   assign w_off_i   = 32'(w_off_eff);
   assign w_idx     = req_addr[OFF_W +: IDX_W];
   assign w_tag     = req_addr[15 -: TAG_W];
   assign w_fidx    = fill_addr[OFF_W +: IDX_W];
   assign w_ftag    = fill_addr[15 -: TAG_W];
   assign req_ready = ~inv_all & ~fill_valid;
   assign w_accept  = req_valid & req_ready;
   assign w_vict    = pick_victim(r_valid[w_idx], r_age[w_idx]);
   assign w_fvict   = pick_victim(r_valid[w_fidx], r_age[w_fidx]);

   always_comb begin
      w_hit     = '0;
      w_hit_way = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         w_hit[w] = r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag);
         if (w_hit[w]) w_hit_way = WAY_W'(w);
      end
      w_hit_any = |w_hit;
   end

   // A zero byte above the line makes the last-byte odd access read {8'h00, byte}.
   assign w_line_ext = {8'h00, r_line[w_idx][w_hit_way]};
   assign w_word     = w_line_ext[{w_off_eff, 3'b000} +: 16];

   always_comb begin
      w_merged = r_line[w_idx][w_hit_way];
      for (int unsigned b = 0; b < LINE_BYTES; b++) begin
         if (b == w_off_i && req_wmask[0])      w_merged[8*b +: 8] = req_wdata[7:0];
         if (b == w_off_i + 1 && req_wmask[1])  w_merged[8*b +: 8] = req_wdata[15:8];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            for (int unsigned w = 0; w < WAYS; w++) r_age[s][w*WAY_W +: WAY_W] <= WAY_W'(w);
         end
      end else if (inv_all) begin
         for (int unsigned s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            for (int unsigned w = 0; w < WAYS; w++) r_age[s][w*WAY_W +: WAY_W] <= WAY_W'(w);
         end
      end else if (fill_valid) begin
         r_valid[w_fidx][w_fvict] <= 1'b1;
         r_dirty[w_fidx][w_fvict] <= 1'b0;
         r_age[w_fidx]            <= touch(r_age[w_fidx], w_fvict);
      end else if (w_accept && w_hit_any) begin
         r_age[w_idx] <= touch(r_age[w_idx], w_hit_way);
         if (req_write) r_dirty[w_idx][w_hit_way] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!inv_all && fill_valid) begin
         r_tag[w_fidx][w_fvict]  <= w_ftag;
         r_line[w_fidx][w_fvict] <= fill_line;
      end else if (w_accept && w_hit_any && req_write) begin
         r_line[w_idx][w_hit_way] <= w_merged;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid    <= 1'b0;
         rsp_hit      <= 1'b0;
         rsp_way      <= '0;
         rsp_rdata    <= '0;
         victim_valid <= 1'b0;
         victim_dirty <= 1'b0;
         victim_tag   <= '0;
         victim_line  <= '0;
      end else begin
         rsp_valid <= w_accept;
         if (w_accept) begin
            rsp_hit      <= w_hit_any;
            rsp_way      <= w_hit_any ? w_hit_way : w_vict;
            rsp_rdata    <= w_hit_any ? w_word : 16'h0000;
            victim_valid <= r_valid[w_idx][w_vict];
            victim_dirty <= r_dirty[w_idx][w_vict];
            victim_tag   <= r_tag[w_idx][w_vict];
            victim_line  <= r_line[w_idx][w_vict];
         end
      end
   end

   a_single_hit: assert property (@(posedge clk) disable iff (!reset_n)
      w_accept |-> $onehot0(w_hit));

endmodule
